// File: rtl/serial_twos_comp_n_pkg.sv
// Shared types and the per-bit transform for the bit-serial complementer.
package stc_pkg;

  typedef enum logic [1:0] {
    STC_PASS = 2'b00,
    STC_ONES = 2'b01,
    STC_TWOS = 2'b10
  } stc_mode_t;

  // Both 2'b10 and 2'b11 select two's complement.
  function automatic logic stc_is_twos(input logic [1:0] mode);
    return mode[1];
  endfunction

  // Two's complement LSB-first: copy bits up to and including the first 1, invert the rest.
  function automatic logic stc_bit(input logic [1:0] mode, input logic seen, input logic i);
    if (mode == STC_PASS) begin
      return i;
    end else if (mode == STC_ONES) begin
      return ~i;
    end else begin
      return seen ? ~i : i;
    end
  endfunction

endpackage

// File: rtl/serial_twos_comp_n_lane.sv
// One serial lane: transform bit, seen-one tracking, output/ovf registers.
// Optional deserialiser slice under STC_PAR_OUT_EN.
module stc_lane
  import stc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             first,
  input  logic             last,
  input  logic [1:0]       mode_eff,
  input  logic             i,
  output logic             y,
  output logic             ovf
`ifdef STC_PAR_OUT_EN
  ,
  output logic [WIDTH-1:0] word_out
`endif
);

  logic seen_one_reg;
  logic y_reg;
  logic ovf_reg;
  logic s;
  logic f;

  assign s = first ? 1'b0 : seen_one_reg;
  assign f = stc_bit(mode_eff, s, i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_one_reg <= 1'b0;
      y_reg        <= 1'b0;
      ovf_reg      <= 1'b0;
    end else if (clr) begin
      seen_one_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else if (in_valid) begin
      y_reg        <= f;
      // Only the most-negative word reaches its sign bit without a prior 1.
      ovf_reg      <= stc_is_twos(mode_eff) && last && i && !s;
      seen_one_reg <= s | i;
    end
  end

  assign y   = y_reg;
  assign ovf = ovf_reg;

`ifdef STC_PAR_OUT_EN
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] word_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      word_reg  <= '0;
    end else if (clr) begin
      shift_reg <= '0;
      word_reg  <= '0;
    end else if (in_valid) begin
      shift_reg <= {f, shift_reg[WIDTH-1:1]};
      if (last) begin
        word_reg <= {f, shift_reg[WIDTH-1:1]};
      end
    end
  end

  assign word_out = word_reg;
`endif

endmodule

// File: rtl/serial_twos_comp_n.sv
// Multi-lane bit-serial pass / one's / two's complementer with shared word framing.
// Define STC_PAR_OUT_EN to add the parallel word_out/word_valid outputs.
module serial_twos_comp_n
  import stc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 1
) (
  input  logic                      t_clk,
  input  logic                      r_n,
  input  logic                      clr,
  input  logic                      in_valid,
  input  logic [CHANNELS-1:0]       i,
  input  logic [1:0]                mode,
  output logic [CHANNELS-1:0]       y,
  output logic                      y_valid,
  output logic                      y_first,
  output logic                      y_last,
  output logic [CHANNELS-1:0]       ovf
`ifdef STC_PAR_OUT_EN
  ,
  output logic [CHANNELS*WIDTH-1:0] word_out,
  output logic                      word_valid
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] bit_cnt_reg;
  stc_mode_t        mode_q_reg;
  logic             y_valid_reg;
  logic             y_first_reg;
  logic             y_last_reg;
  logic             first;
  logic             last;
  logic [1:0]       mode_eff;

  assign first    = (bit_cnt_reg == '0);
  assign last     = (bit_cnt_reg == CNT_W'(WIDTH - 1));
  assign mode_eff = first ? mode : mode_q_reg;

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      bit_cnt_reg <= '0;
      mode_q_reg  <= STC_PASS;
      y_valid_reg <= 1'b0;
      y_first_reg <= 1'b0;
      y_last_reg  <= 1'b0;
    end else if (clr) begin
      bit_cnt_reg <= '0;
      y_valid_reg <= 1'b0;
    end else if (in_valid) begin
      bit_cnt_reg <= last ? '0 : bit_cnt_reg + CNT_W'(1);
      if (first) begin
        mode_q_reg <= stc_mode_t'(mode);
      end
      y_valid_reg <= 1'b1;
      y_first_reg <= first;
      y_last_reg  <= last;
    end else begin
      y_valid_reg <= 1'b0;
    end
  end

  assign y_valid = y_valid_reg;
  assign y_first = y_first_reg;
  assign y_last  = y_last_reg;

`ifdef STC_PAR_OUT_EN
  logic word_valid_reg;

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      word_valid_reg <= 1'b0;
    end else if (clr) begin
      word_valid_reg <= 1'b0;
    end else begin
      word_valid_reg <= in_valid && last;
    end
  end

  assign word_valid = word_valid_reg;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    stc_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk      (t_clk),
      .rst_n    (r_n),
      .clr      (clr),
      .in_valid (in_valid),
      .first    (first),
      .last     (last),
      .mode_eff (mode_eff),
      .i        (i[gi]),
      .y        (y[gi]),
      .ovf      (ovf[gi])
`ifdef STC_PAR_OUT_EN
      ,
      .word_out (word_out[gi*WIDTH +: WIDTH])
`endif
    );
  end

endmodule

// File: tb/tb_serial_twos_comp_n.sv
// Self-checking bench: word table plus hand sequences, per-bit scoreboard checked at negedge.
module tb_serial_twos_comp_n;

  localparam int W  = 8;
  localparam int CH = 2;

  logic          t_clk = 1'b0;
  logic          r_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [CH-1:0] i = '0;
  logic [1:0]    mode = 2'b00;
  logic [CH-1:0] y;
  logic          y_valid;
  logic          y_first;
  logic          y_last;
  logic [CH-1:0] ovf;
`ifdef STC_PAR_OUT_EN
  logic [CH*W-1:0] word_out;
  logic            word_valid;
`endif

  serial_twos_comp_n #(
    .WIDTH(W),
    .CHANNELS(CH)
  ) dut (
    .t_clk    (t_clk),
    .r_n      (r_n),
    .clr      (clr),
    .in_valid (in_valid),
    .i        (i),
    .mode     (mode),
    .y        (y),
    .y_valid  (y_valid),
    .y_first  (y_first),
    .y_last   (y_last),
    .ovf      (ovf)
`ifdef STC_PAR_OUT_EN
    ,
    .word_out   (word_out),
    .word_valid (word_valid)
`endif
  );

  always #5 t_clk = ~t_clk;

  typedef struct {
    logic [CH-1:0]   y;
    logic            first;
    logic            last;
    logic [CH-1:0]   ovf;
    logic [CH*W-1:0] word;
  } exp_t;

  typedef struct {
    logic [1:0]    mode_a;
    logic [1:0]    mode_b;
    int            chg_at;
    int            gap_at;
    int            gap_len;
    logic [W-1:0]  in0;
    logic [W-1:0]  in1;
    logic [W-1:0]  exp0;
    logic [W-1:0]  exp1;
    logic [CH-1:0] ovf;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[11];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_bit(input int b, input logic [W-1:0] e0, input logic [W-1:0] e1,
                          input logic [CH-1:0] ov);
    exp_t e;
    e.y     = {e1[b], e0[b]};
    e.first = (b == 0);
    e.last  = (b == W - 1);
    e.ovf   = (b == W - 1) ? ov : '0;
    e.word  = {e1, e0};
    sb.push_back(e);
  endtask

  task automatic send_bit(input logic [CH-1:0] b, input logic [1:0] m, input logic c);
    i        = b;
    mode     = m;
    in_valid = 1'b1;
    clr      = c;
    @(posedge t_clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic send_word(input vec_t v);
    logic [1:0] m;
    for (int b = 0; b < W; b++) begin
      m = (b >= v.chg_at) ? v.mode_b : v.mode_a;
      push_bit(b, v.exp0, v.exp1, v.ovf);
      send_bit({v.in1[b], v.in0[b]}, m, 1'b0);
      if (b == v.gap_at) begin
        for (int g = 0; g < v.gap_len; g++) begin
          @(posedge t_clk);
          #1;
          check("gap_y_valid", y_valid, 0);
        end
      end
    end
    $display("word mode=%b in=%02h/%02h expect=%02h/%02h ovf=%b",
             v.mode_a, v.in0, v.in1, v.exp0, v.exp1, v.ovf);
  endtask

  // Scoreboard: every valid output bit must match the oldest pending expectation.
  always @(negedge t_clk) begin
    exp_t e;
    if (y_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bit: got y_valid=1 y=%b expected no output", y);
      end else begin
        e = sb.pop_front();
        check("y", y, e.y);
        check("y_first", y_first, e.first);
        check("y_last", y_last, e.last);
        check("ovf", ovf, e.ovf);
`ifdef STC_PAR_OUT_EN
        check("word_valid", word_valid, e.last);
        if (e.last) check("word_out", word_out, e.word);
`endif
      end
    end
  end

  initial begin
    vec_t v;
    //           mode_a mode_b chg gap len in0    in1    exp0   exp1   ovf
    vecs[0]  = '{2'b10, 2'b10, 8, -1, 0, 8'h06, 8'h80, 8'hFA, 8'h80, 2'b10};
    vecs[1]  = '{2'b10, 2'b10, 8, -1, 0, 8'h80, 8'h06, 8'h80, 8'hFA, 2'b01};
    vecs[2]  = '{2'b10, 2'b10, 8, -1, 0, 8'h00, 8'h01, 8'h00, 8'hFF, 2'b00};
    vecs[3]  = '{2'b10, 2'b10, 8, -1, 0, 8'h01, 8'hFF, 8'hFF, 8'h01, 2'b00};
    vecs[4]  = '{2'b00, 2'b00, 8, -1, 0, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 2'b00};
    vecs[5]  = '{2'b00, 2'b00, 8, -1, 0, 8'h80, 8'h80, 8'h80, 8'h80, 2'b00};
    vecs[6]  = '{2'b01, 2'b01, 8, -1, 0, 8'h5A, 8'h80, 8'hA5, 8'h7F, 2'b00};
    vecs[7]  = '{2'b01, 2'b10, 3, -1, 0, 8'h5A, 8'h06, 8'hA5, 8'hF9, 2'b00};
    vecs[8]  = '{2'b10, 2'b10, 8, -1, 0, 8'h5A, 8'h06, 8'hA6, 8'hFA, 2'b00};
    vecs[9]  = '{2'b11, 2'b11, 8, -1, 0, 8'h5A, 8'h80, 8'hA6, 8'h80, 2'b10};
    vecs[10] = '{2'b10, 2'b10, 8,  2, 3, 8'h06, 8'h7F, 8'hFA, 8'h81, 2'b00};

    #2;
    check("rst_y", y, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_y_first", y_first, 0);
    check("rst_y_last", y_last, 0);
    check("rst_ovf", ovf, 0);
`ifdef STC_PAR_OUT_EN
    check("rst_word_out", word_out, 0);
    check("rst_word_valid", word_valid, 0);
`endif
    @(posedge t_clk);
    #1;
    r_n = 1'b1;

    foreach (vecs[k]) send_word(vecs[k]);

    // clr at bit 4 drops that bit and restarts framing.
    v = '{2'b10, 2'b10, 8, -1, 0, 8'h33, 8'h0C, 8'hCD, 8'hF4, 2'b00};
    for (int b = 0; b < 4; b++) begin
      push_bit(b, v.exp0, v.exp1, v.ovf);
      send_bit({v.in1[b], v.in0[b]}, v.mode_a, 1'b0);
    end
    send_bit({v.in1[4], v.in0[4]}, v.mode_a, 1'b1);
    check("clr_y_valid", y_valid, 0);
    check("clr_ovf", ovf, 0);
`ifdef STC_PAR_OUT_EN
    check("clr_word_out", word_out, 0);
    check("clr_word_valid", word_valid, 0);
`endif
    $display("clr at bit 4 applied");
    send_word('{2'b10, 2'b10, 8, -1, 0, 8'h01, 8'h80, 8'hFF, 8'h80, 2'b10});

    // Asynchronous reset mid-word, with the bit-2 output still showing.
    v = '{2'b10, 2'b10, 8, -1, 0, 8'h03, 8'h04, 8'hFD, 8'hFC, 2'b00};
    for (int b = 0; b < 3; b++) begin
      push_bit(b, v.exp0, v.exp1, v.ovf);
      send_bit({v.in1[b], v.in0[b]}, v.mode_a, 1'b0);
    end
    check("pre_rst_y", y, 2'b11);
    r_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_y", y, 0);
    check("midrst_y_valid", y_valid, 0);
    check("midrst_y_first", y_first, 0);
    check("midrst_y_last", y_last, 0);
    check("midrst_ovf", ovf, 0);
`ifdef STC_PAR_OUT_EN
    check("midrst_word_out", word_out, 0);
`endif
    #2;
    r_n = 1'b1;
    $display("reset mid-word applied");
    send_word('{2'b10, 2'b10, 8, -1, 0, 8'h06, 8'h80, 8'hFA, 8'h80, 2'b10});

    for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge t_clk);
    @(posedge t_clk);
    #1;
    check("drain_pending", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
